// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone encodings and arbiter FSM state type.
package peripheral_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
    localparam logic [2:0] CTI_INC_BURST    = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/peripheral_arbiter_rr_wb.sv
// Combinational round-robin picker: lowest requester above last_i wins, else lowest overall.
module peripheral_arbiter_rr_wb #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_i,
    output logic [NUM_MASTERS-1:0] gnt_o
);

    logic [NUM_MASTERS-1:0] req_hi;
    logic [NUM_MASTERS-1:0] pick;

    always_comb begin
        req_hi = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            req_hi[k] = req_i[k] && (IDX_W'(k) > last_i);
        end
        pick = (|req_hi) ? req_hi : req_i;

        // Walk downward so the lowest set bit is the one left standing.
        gnt_o = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (pick[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// N-to-1 Wishbone arbiter with round-robin grant held for the whole cycle.
// Optional stall watchdog enabled by defining PERIPHERAL_ARBITER_WB_TIMEOUT_EN.
module peripheral_arbiter_wb
    import peripheral_wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]    m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]    m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]       m_we_i,
    input  logic [NUM_MASTERS-1:0]       m_cyc_i,
    input  logic [NUM_MASTERS-1:0]       m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]     m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]     m_bte_i,
    output logic [DW-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]       m_ack_o,
    output logic [NUM_MASTERS-1:0]       m_err_o,
    output logic [NUM_MASTERS-1:0]       m_rty_o,
    output logic [AW-1:0]                s_adr_o,
    output logic [DW-1:0]                s_dat_o,
    output logic [DW/8-1:0]              s_sel_o,
    output logic                         s_we_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic [2:0]                   s_cti_o,
    output logic [1:0]                   s_bte_o,
    input  logic [DW-1:0]                s_dat_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,
    input  logic                         s_rty_i,
    output logic [NUM_MASTERS-1:0]       grant_o
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IdxW-1:0]        last_q, last_d;

    logic [NUM_MASTERS-1:0] rr_gnt;
    logic [IdxW-1:0]        grant_idx;
    logic                   granted_cyc;
    logic                   mux_cyc;
    logic                   mux_stb;
    logic                   wdog_fire;

    peripheral_arbiter_rr_wb #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IdxW)
    ) u_rr (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    // Request mux; grant_q is all-zero in IDLE so every slave output reads 0 there.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        mux_cyc   = 1'b0;
        mux_stb   = 1'b0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                s_adr_o   = m_adr_i[k*AW +: AW];
                s_dat_o   = m_dat_i[k*DW +: DW];
                s_sel_o   = m_sel_i[k*SW +: SW];
                s_we_o    = m_we_i[k];
                mux_cyc   = m_cyc_i[k];
                mux_stb   = m_stb_i[k];
                s_cti_o   = m_cti_i[k*3 +: 3];
                s_bte_o   = m_bte_i[k*2 +: 2];
                grant_idx = IdxW'(k);
            end
        end
    end

    assign granted_cyc = |(m_cyc_i & grant_q);
    assign s_cyc_o     = mux_cyc & ~wdog_fire;
    assign s_stb_o     = mux_stb & ~wdog_fire;
    assign grant_o     = grant_q;
    assign m_dat_o     = (state_q == StGrant) ? s_dat_i : '0;
    assign m_ack_o     = grant_q & {NUM_MASTERS{s_ack_i & ~wdog_fire}};
    assign m_rty_o     = grant_q & {NUM_MASTERS{s_rty_i & ~wdog_fire}};
    assign m_err_o     = grant_q & {NUM_MASTERS{s_err_i | wdog_fire}};

`ifdef PERIPHERAL_ARBITER_WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] wdog_q, wdog_d;
    logic            term;

    assign term      = s_ack_i | s_err_i | s_rty_i;
    assign wdog_fire = (state_q == StGrant) && (wdog_q >= CntW'(TIMEOUT));

    always_comb begin
        wdog_d = wdog_q;
        if (state_q != StGrant || wdog_fire || term) begin
            wdog_d = '0;
        end else if (mux_stb) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    state_d = StGrant;
                    grant_d = rr_gnt;
                end
            end
            StGrant: begin
                if (!granted_cyc || wdog_fire) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = grant_idx;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdxW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
